cpu_ctrl: RTL and testbench
===========================

CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 s  input  1  start request, level-sampled in WAIT.
REQ-005 load  input  1  instruction-register load enable.
REQ-006 instr_in  input  16  instruction word.
REQ-007 w  output  1  idle/ready, high only in WAIT.
REQ-008 readnum, writenum  output  3 each  register-file read and write addresses.
REQ-009 vsel, asel, bsel, loada, loadb, loadc, loads, write  output  1 each  datapath control strobes.
REQ-010 shift, ALUop  output  2 each  shifter and ALU op selects.
REQ-011 datapath_in  output  16  immediate to datapath, sign-extended IR[7:0].
REQ-012 halted  output  1  illegal-instruction trap flag (see Configuration).

Function
REQ-013 The 16-bit IR SHALL load from instr_in on a clk edge with load=1 in WAIT; load SHALL be ignored in all other states.
REQ-014 IR fields SHALL be: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0], imm8=IR[7:0].
REQ-015 States SHALL be WAIT, DECODE, GET_A, GET_B, ALU, CMP, WRITE_REG, WRITE_IMM, HALT; outputs are Moore (state plus IR only).
REQ-016 WAIT SHALL go to DECODE on an edge with s=1; if load and s are both high, DECODE SHALL use the newly loaded IR.
REQ-017 DECODE routing: 110/10 (MOV imm) -> WRITE_IMM; 110/00 (MOV reg) and 101/11 (MVN) -> GET_B; 101/00 (ADD), 101/01 (CMP), 101/10 (AND) -> GET_A; any other encoding is illegal.
REQ-018 GET_A -> GET_B; GET_B -> CMP if op=01 and opcode=101, else ALU; ALU -> WRITE_REG; CMP, WRITE_REG and WRITE_IMM -> WAIT.
REQ-019 Per-state assertions (all unlisted strobes 0, readnum/writenum 0): GET_A readnum=Rn, loada=1; GET_B readnum=Rm, loadb=1; ALU shift=sh, loadc=1, asel=1 for MOV reg/MVN else 0, ALUop=00 for MOV reg else op; CMP shift=sh, ALUop=01, loads=1, loadc=0; WRITE_REG writenum=Rd, vsel=0, write=1; WRITE_IMM writenum=Rn, vsel=1, write=1.
REQ-020 bsel SHALL be 0 in every state; datapath_in SHALL equal {8{IR[7]},IR[7:0]} in every state.
REQ-021 Non-WAIT cycles per instruction SHALL be: MOV imm 2, MOV reg 4, MVN 4, CMP 4, ADD/AND 5.
REQ-022 write SHALL be 1 for exactly one cycle per MOV/ADD/AND/MVN and never for CMP.
REQ-023 With s held high, a new instruction SHALL start on the edge after WAIT is re-entered (one WAIT cycle between instructions).

Reset
REQ-024 On a reset edge from any state, the next cycle SHALL be WAIT with IR=0x0000, halted=0, w=1 and all other outputs 0 except datapath_in=0x0000.
REQ-025 Reset SHALL take priority over s and load; an in-flight instruction SHALL be abandoned and SHALL NOT assert write after the reset edge.

Configuration
REQ-026 Macro CPU_CTRL_ILLEGAL_TRAP_EN: if defined, an illegal encoding SHALL go DECODE -> HALT; HALT holds halted=1, w=0 and all strobes 0 until reset.
REQ-027 If CPU_CTRL_ILLEGAL_TRAP_EN is undefined, an illegal encoding SHALL go DECODE -> WAIT as a NOP, HALT SHALL not exist, and halted SHALL be constant 0.

Verification
REQ-028 Load 0xD107, pulse s -> WRITE_IMM asserts write=1, writenum=1, vsel=1, datapath_in=0x0007; w=1 again 2 cycles after leaving WAIT.
REQ-029 Load 0xD2FF, s -> datapath_in=0xFFFF, writenum=2 during the write cycle.
REQ-030 Load 0xA148 (ADD R2,R1,R0 LSL1), s -> GET_A readnum=1 loada; GET_B readnum=0 loadb; ALU shift=01 ALUop=00 asel=0 loadc; WRITE_REG writenum=2 write; 5 non-WAIT cycles.
REQ-031 Load 0xA900 (CMP R1,R0), s -> CMP state ALUop=01 loads=1 loadc=0; write never 1; w=1 after 4 cycles.
REQ-032 Start 0xA148, assert reset during GET_B -> next cycle w=1, IR=0, all strobes 0, no write pulse.
REQ-033 Load 0x0000, s -> with macro, halted=1 and w=0 persist until reset; without it, w=1 after 1 cycle, no strobes asserted.

Source files
------------

// File: rtl/cpu_ctrl_if.sv
// cpu_ctrl_if: bundles the start/load/instruction inputs and every datapath
// control output of cpu_ctrl. The master side (sequencer/bench) drives the
// request signals; the slave side (cpu_ctrl) drives the control strobes.
interface cpu_ctrl_if;
  logic        s;
  logic        load;
  logic [15:0] instr_in;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        vsel;
  logic        asel;
  logic        bsel;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        write;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] datapath_in;
  logic        halted;

  modport master (
    output s, load, instr_in,
    input  w, readnum, writenum, vsel, asel, bsel, loada, loadb, loadc,
           loads, write, shift, ALUop, datapath_in, halted
  );

  modport slave (
    input  s, load, instr_in,
    output w, readnum, writenum, vsel, asel, bsel, loada, loadb, loadc,
           loads, write, shift, ALUop, datapath_in, halted
  );
endinterface

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle controller for a simple datapath. Holds the
// instruction register and sequences MOV imm / MOV reg / MVN / ADD / CMP / AND.
// Optional feature macro: CPU_CTRL_ILLEGAL_TRAP_EN -- when defined, an illegal
// encoding traps into HALT (halted=1) until reset; otherwise it is a NOP.
// All outputs are registered from the next state/IR so they line up with the
// state they belong to.
module cpu_ctrl (
  input  logic         clk,
  input  logic         reset,
  cpu_ctrl_if.slave    bus
);

  localparam int unsigned IR_W  = 16;
  localparam int unsigned REG_W = 3;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned IMM_W = 8;

  typedef enum logic [3:0] {
    S_WAIT,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_ALU,
    S_CMP,
    S_WRITE_REG,
    S_WRITE_IMM
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    , S_HALT
`endif
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IR_W-1:0]   r_ir;
  logic [IR_W-1:0]   w_ir_nxt;

  // registered outputs
  logic              r_w;
  logic [REG_W-1:0]  r_readnum;
  logic [REG_W-1:0]  r_writenum;
  logic              r_vsel;
  logic              r_asel;
  logic              r_loada;
  logic              r_loadb;
  logic              r_loadc;
  logic              r_loads;
  logic              r_write;
  logic [SEL_W-1:0]  r_shift;
  logic [SEL_W-1:0]  r_aluop;
  logic [IR_W-1:0]   r_datapath_in;
  logic              r_halted;

  // next-cycle output values
  logic              w_w;
  logic [REG_W-1:0]  w_readnum;
  logic [REG_W-1:0]  w_writenum;
  logic              w_vsel;
  logic              w_asel;
  logic              w_loada;
  logic              w_loadb;
  logic              w_loadc;
  logic              w_loads;
  logic              w_write;
  logic [SEL_W-1:0]  w_shift;
  logic [SEL_W-1:0]  w_aluop;
  logic [IR_W-1:0]   w_datapath_in;
  logic              w_halted;

  // routing fields come from the settled IR (stable once out of WAIT)
  logic [2:0]        w_dec_opc;
  logic [1:0]        w_dec_op;
  // output fields come from the IR that will be held next cycle
  logic [2:0]        w_opc;
  logic [1:0]        w_op;
  logic [REG_W-1:0]  w_rn;
  logic [REG_W-1:0]  w_rd;
  logic [SEL_W-1:0]  w_sh;
  logic [REG_W-1:0]  w_rm;
  logic              w_is_movreg;
  logic              w_is_mvn;

  assign w_dec_opc   = r_ir[15:13];
  assign w_dec_op    = r_ir[12:11];
  assign w_opc       = w_ir_nxt[15:13];
  assign w_op        = w_ir_nxt[12:11];
  assign w_rn        = w_ir_nxt[10:8];
  assign w_rd        = w_ir_nxt[7:5];
  assign w_sh        = w_ir_nxt[4:3];
  assign w_rm        = w_ir_nxt[2:0];
  assign w_is_movreg = (w_opc == 3'b110) && (w_op == 2'b00);
  assign w_is_mvn    = (w_opc == 3'b101) && (w_op == 2'b11);

  // next state, IR capture, and Moore output decode of the next state
  always_comb begin
    w_state_nxt   = r_state;
    w_ir_nxt      = r_ir;
    w_w           = 1'b0;
    w_readnum     = '0;
    w_writenum    = '0;
    w_vsel        = 1'b0;
    w_asel        = 1'b0;
    w_loada       = 1'b0;
    w_loadb       = 1'b0;
    w_loadc       = 1'b0;
    w_loads       = 1'b0;
    w_write       = 1'b0;
    w_shift       = '0;
    w_aluop       = '0;
    w_datapath_in = '0;
    w_halted      = 1'b0;

    case (r_state)
      S_WAIT: begin
        if (bus.load) w_ir_nxt = bus.instr_in;
        if (bus.s)    w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (w_dec_opc == 3'b110 && w_dec_op == 2'b10)
          w_state_nxt = S_WRITE_IMM;
        else if ((w_dec_opc == 3'b110 && w_dec_op == 2'b00) ||
                 (w_dec_opc == 3'b101 && w_dec_op == 2'b11))
          w_state_nxt = S_GET_B;
        else if (w_dec_opc == 3'b101)
          w_state_nxt = S_GET_A;
        else
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
          w_state_nxt = S_HALT;
`else
          w_state_nxt = S_WAIT;
`endif
      end
      S_GET_A:     w_state_nxt = S_GET_B;
      S_GET_B:     w_state_nxt = (w_dec_opc == 3'b101 && w_dec_op == 2'b01) ? S_CMP : S_ALU;
      S_ALU:       w_state_nxt = S_WRITE_REG;
      S_CMP:       w_state_nxt = S_WAIT;
      S_WRITE_REG: w_state_nxt = S_WAIT;
      S_WRITE_IMM: w_state_nxt = S_WAIT;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
      S_HALT:      w_state_nxt = S_HALT;
`endif
      default:     w_state_nxt = S_WAIT;
    endcase

    w_datapath_in = {{(IR_W-IMM_W){w_ir_nxt[IMM_W-1]}}, w_ir_nxt[IMM_W-1:0]};

    case (w_state_nxt)
      S_WAIT:      w_w = 1'b1;
      S_GET_A: begin
        w_readnum = w_rn;
        w_loada   = 1'b1;
      end
      S_GET_B: begin
        w_readnum = w_rm;
        w_loadb   = 1'b1;
      end
      S_ALU: begin
        w_shift = w_sh;
        w_loadc = 1'b1;
        w_asel  = w_is_movreg || w_is_mvn;
        w_aluop = w_is_movreg ? 2'b00 : w_op;
      end
      S_CMP: begin
        w_shift = w_sh;
        w_aluop = 2'b01;
        w_loads = 1'b1;
      end
      S_WRITE_REG: begin
        w_writenum = w_rd;
        w_write    = 1'b1;
      end
      S_WRITE_IMM: begin
        w_writenum = w_rn;
        w_vsel     = 1'b1;
        w_write    = 1'b1;
      end
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
      S_HALT:      w_halted = 1'b1;
`endif
      default: ;
    endcase
  end

  // state, IR and output registers; reset wins over s and load
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_WAIT;
      r_ir          <= '0;
      r_w           <= 1'b1;
      r_readnum     <= '0;
      r_writenum    <= '0;
      r_vsel        <= 1'b0;
      r_asel        <= 1'b0;
      r_loada       <= 1'b0;
      r_loadb       <= 1'b0;
      r_loadc       <= 1'b0;
      r_loads       <= 1'b0;
      r_write       <= 1'b0;
      r_shift       <= '0;
      r_aluop       <= '0;
      r_datapath_in <= '0;
      r_halted      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ir          <= w_ir_nxt;
      r_w           <= w_w;
      r_readnum     <= w_readnum;
      r_writenum    <= w_writenum;
      r_vsel        <= w_vsel;
      r_asel        <= w_asel;
      r_loada       <= w_loada;
      r_loadb       <= w_loadb;
      r_loadc       <= w_loadc;
      r_loads       <= w_loads;
      r_write       <= w_write;
      r_shift       <= w_shift;
      r_aluop       <= w_aluop;
      r_datapath_in <= w_datapath_in;
      r_halted      <= w_halted;
    end
  end

  assign bus.w           = r_w;
  assign bus.readnum     = r_readnum;
  assign bus.writenum    = r_writenum;
  assign bus.vsel        = r_vsel;
  assign bus.asel        = r_asel;
  assign bus.bsel        = 1'b0;
  assign bus.loada       = r_loada;
  assign bus.loadb       = r_loadb;
  assign bus.loadc       = r_loadc;
  assign bus.loads       = r_loads;
  assign bus.write       = r_write;
  assign bus.shift       = r_shift;
  assign bus.ALUop       = r_aluop;
  assign bus.datapath_in = r_datapath_in;
  assign bus.halted      = r_halted;

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb_cpu_ctrl: directed-vector bench for cpu_ctrl. The driver pushes the
// hand-computed per-cycle control word for each instruction into a queue;
// the monitor pops one entry per cycle and compares it with the DUT outputs.
module tb_cpu_ctrl;

  typedef struct packed {
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        vsel;
    logic        asel;
    logic        bsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        write;
    logic [1:0]  shift;
    logic [1:0]  aluop;
    logic [15:0] dp;
    logic        halted;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  cpu_ctrl_if bus();

  cpu_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_vec  = 0;
  int    n_miss = 0;

  // per-state expected control words
  function automatic exp_t e_base(input logic [15:0] dp);
    exp_t e;
    e = '0;
    e.dp = dp;
    return e;
  endfunction
  function automatic exp_t e_wait(input logic [15:0] dp);
    exp_t e; e = e_base(dp); e.w = 1'b1; return e;
  endfunction
  function automatic exp_t e_dec(input logic [15:0] dp);
    return e_base(dp);
  endfunction
  function automatic exp_t e_geta(input logic [2:0] rn, input logic [15:0] dp);
    exp_t e; e = e_base(dp); e.readnum = rn; e.loada = 1'b1; return e;
  endfunction
  function automatic exp_t e_getb(input logic [2:0] rm, input logic [15:0] dp);
    exp_t e; e = e_base(dp); e.readnum = rm; e.loadb = 1'b1; return e;
  endfunction
  function automatic exp_t e_alu(input logic [1:0] sh, input logic [1:0] op,
                                 input logic asel, input logic [15:0] dp);
    exp_t e; e = e_base(dp);
    e.shift = sh; e.aluop = op; e.asel = asel; e.loadc = 1'b1;
    return e;
  endfunction
  function automatic exp_t e_cmp(input logic [1:0] sh, input logic [15:0] dp);
    exp_t e; e = e_base(dp);
    e.shift = sh; e.aluop = 2'b01; e.loads = 1'b1;
    return e;
  endfunction
  function automatic exp_t e_wreg(input logic [2:0] rd, input logic [15:0] dp);
    exp_t e; e = e_base(dp); e.writenum = rd; e.write = 1'b1; return e;
  endfunction
  function automatic exp_t e_wimm(input logic [2:0] rn, input logic [15:0] dp);
    exp_t e; e = e_base(dp); e.writenum = rn; e.vsel = 1'b1; e.write = 1'b1; return e;
  endfunction
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
  function automatic exp_t e_halt(input logic [15:0] dp);
    exp_t e; e = e_base(dp); e.halted = 1'b1; return e;
  endfunction
`endif

  task automatic push(input exp_t e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // one-cycle start pulse with a simultaneous IR load
  task automatic go(input logic [15:0] ins);
    bus.s = 1'b1; bus.load = 1'b1; bus.instr_in = ins;
    @(negedge clk);
    bus.s = 1'b0; bus.load = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      $display("FAIL %s: %0d expected vectors never consumed (required 0)", nm, exp_q.size());
      $fatal(1, "scoreboard stalled");
    end
  endtask

  // monitor: one comparison per cycle while expectations are pending
  always begin
    exp_t  e;
    exp_t  a;
    string nm;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a.w        = bus.w;
      a.readnum  = bus.readnum;
      a.writenum = bus.writenum;
      a.vsel     = bus.vsel;
      a.asel     = bus.asel;
      a.bsel     = bus.bsel;
      a.loada    = bus.loada;
      a.loadb    = bus.loadb;
      a.loadc    = bus.loadc;
      a.loads    = bus.loads;
      a.write    = bus.write;
      a.shift    = bus.shift;
      a.aluop    = bus.ALUop;
      a.dp       = bus.datapath_in;
      a.halted   = bus.halted;
      n_vec++;
      if (a !== e) begin
        n_miss++;
        $display("FAIL %s: got %h required %h", nm, a, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; bus.s = 1'b0; bus.load = 1'b0; bus.instr_in = 16'h0000;
    @(negedge clk);

    // reset state
    push(e_wait(16'h0000), "reset");
    tick(1);
    reset = 1'b0;
    drain("reset");

    // load without start: stays in WAIT, immediate tracks new IR
    push(e_wait(16'h0055), "load_only");
    bus.load = 1'b1; bus.instr_in = 16'h0055;
    tick(1);
    bus.load = 1'b0;
    drain("load_only");

    // MOV R1,#7
    push(e_dec(16'h0007), "movimm_dec");
    push(e_wimm(3'd1, 16'h0007), "movimm_wr");
    push(e_wait(16'h0007), "movimm_wait");
    go(16'hD107);
    drain("movimm");

    // MOV R2,#-1 with a load attempt during DECODE that must be ignored
    push(e_dec(16'hFFFF), "movneg_dec");
    push(e_wimm(3'd2, 16'hFFFF), "movneg_wr");
    push(e_wait(16'hFFFF), "movneg_wait");
    bus.s = 1'b1; bus.load = 1'b1; bus.instr_in = 16'hD2FF;
    tick(1);
    bus.s = 1'b0; bus.load = 1'b1; bus.instr_in = 16'h1234;
    tick(1);
    bus.load = 1'b0;
    drain("movneg");

    // ADD R2,R1,R0 LSL1
    push(e_dec(16'h0048), "add_dec");
    push(e_geta(3'd1, 16'h0048), "add_geta");
    push(e_getb(3'd0, 16'h0048), "add_getb");
    push(e_alu(2'b01, 2'b00, 1'b0, 16'h0048), "add_alu");
    push(e_wreg(3'd2, 16'h0048), "add_wr");
    push(e_wait(16'h0048), "add_wait");
    go(16'hA148);
    drain("add");

    // CMP R1,R0
    push(e_dec(16'h0000), "cmp_dec");
    push(e_geta(3'd1, 16'h0000), "cmp_geta");
    push(e_getb(3'd0, 16'h0000), "cmp_getb");
    push(e_cmp(2'b00, 16'h0000), "cmp_cmp");
    push(e_wait(16'h0000), "cmp_wait");
    go(16'hA900);
    drain("cmp");

    // MOV R5,R3 LSL1
    push(e_dec(16'hFFAB), "movr_dec");
    push(e_getb(3'd3, 16'hFFAB), "movr_getb");
    push(e_alu(2'b01, 2'b00, 1'b1, 16'hFFAB), "movr_alu");
    push(e_wreg(3'd5, 16'hFFAB), "movr_wr");
    push(e_wait(16'hFFAB), "movr_wait");
    go(16'hC0AB);
    drain("movr");

    // MVN R1,R2 LSR1
    push(e_dec(16'h0032), "mvn_dec");
    push(e_getb(3'd2, 16'h0032), "mvn_getb");
    push(e_alu(2'b10, 2'b11, 1'b1, 16'h0032), "mvn_alu");
    push(e_wreg(3'd1, 16'h0032), "mvn_wr");
    push(e_wait(16'h0032), "mvn_wait");
    go(16'hB832);
    drain("mvn");

    // AND R4,R3,R6
    push(e_dec(16'hFF86), "and_dec");
    push(e_geta(3'd3, 16'hFF86), "and_geta");
    push(e_getb(3'd6, 16'hFF86), "and_getb");
    push(e_alu(2'b00, 2'b10, 1'b0, 16'hFF86), "and_alu");
    push(e_wreg(3'd4, 16'hFF86), "and_wr");
    push(e_wait(16'hFF86), "and_wait");
    go(16'hB386);
    drain("and");

    // s held high: back-to-back MOV imm with one WAIT cycle between
    push(e_dec(16'h0007), "b2b_dec0");
    push(e_wimm(3'd1, 16'h0007), "b2b_wr0");
    push(e_wait(16'h0007), "b2b_wait0");
    push(e_dec(16'h0007), "b2b_dec1");
    push(e_wimm(3'd1, 16'h0007), "b2b_wr1");
    push(e_wait(16'h0007), "b2b_wait1");
    push(e_wait(16'h0007), "b2b_idle");
    bus.s = 1'b1; bus.load = 1'b1; bus.instr_in = 16'hD107;
    tick(1);
    bus.load = 1'b0;
    tick(5);
    bus.s = 1'b0;
    drain("b2b");

    // reset during GET_B abandons the ADD without a write
    push(e_dec(16'h0048), "rst_dec");
    push(e_geta(3'd1, 16'h0048), "rst_geta");
    push(e_getb(3'd0, 16'h0048), "rst_getb");
    push(e_wait(16'h0000), "rst_wait0");
    push(e_wait(16'h0000), "rst_wait1");
    go(16'hA148);
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    drain("rst_mid");

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    // illegal encodings trap and stay halted (even with s high) until reset
    push(e_dec(16'h0000), "ill0_dec");
    push(e_halt(16'h0000), "ill0_halt0");
    push(e_halt(16'h0000), "ill0_halt1");
    push(e_halt(16'h0000), "ill0_halt2");
    push(e_wait(16'h0000), "ill0_rst");
    go(16'h0000);
    bus.s = 1'b1;
    tick(3);
    bus.s = 1'b0; reset = 1'b1;
    tick(1);
    reset = 1'b0;
    drain("ill0");

    push(e_dec(16'hFFFF), "ill1_dec");
    push(e_halt(16'hFFFF), "ill1_halt0");
    push(e_halt(16'hFFFF), "ill1_halt1");
    push(e_halt(16'hFFFF), "ill1_halt2");
    push(e_wait(16'h0000), "ill1_rst");
    go(16'hC8FF);
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    drain("ill1");
`else
    // illegal encodings are a one-cycle NOP
    push(e_dec(16'h0000), "ill0_dec");
    push(e_wait(16'h0000), "ill0_wait");
    go(16'h0000);
    drain("ill0");

    push(e_dec(16'hFFFF), "ill1_dec");
    push(e_wait(16'hFFFF), "ill1_wait");
    go(16'hC8FF);
    drain("ill1");

    push(e_dec(16'hFF80), "ill2_dec");
    push(e_wait(16'hFF80), "ill2_wait");
    go(16'hE080);
    drain("ill2");
`endif

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
